e_collect_nxn: RTL and testbench
================================

# e_collect_nxn

Column-to-row collector for the 4x4 LABFT datapath: the receive-side counterpart of the row-load/column-shift move buffer. It accepts one column word per beat (element j on line j), stores a full 4x4 tile, then drains it one row per beat on a valid/ready output. The result is an in-place transpose back to row order. It sits at the output of the systolic array, ahead of the checksum/compare logic.

## Interface
- arraySize, 4, tile dimension; the port list is fixed at 4 lines, so only 4 is legal
- zBits, 8, element width on both input and output lines
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  column beat present on e_0_in..e_3_in
- in_ready  out  1  collector can accept a column beat
- e_0_in..e_3_in  in  zBits each  column element from line 0..3
- out_valid  out  1  row beat present on e_0_out..e_3_out
- out_ready  in  1  downstream accepts the row beat
- e_0_out..e_3_out  out  zBits each  row element for column 0..3
- busy  out  1  tile partially or fully held (state != IDLE)

## Operation
- Storage: matrix M[4][4] of zBits registers, plus a 2-bit column counter col and a 2-bit row counter row.
- Accept: an input beat is accepted when in_valid && in_ready. On accept, M[j][col] <= e_j_in for j = 0..3, and col increments.
- FSM states and transitions:
  - IDLE -> FILL on the first accept (col 0 written).
  - FILL -> DRAIN on the accept that writes col 3. col wraps to 0.
  - DRAIN -> IDLE on the handshake of row 3. row wraps to 0.
- in_ready = (state != DRAIN). Input is stalled for the whole drain; there is no double buffering.
- out_valid = (state == DRAIN), registered via the state.
- e_k_out = M[row][k] while out_valid is high, and all zeros otherwise.
- row increments on out_valid && out_ready. Data on the output is held stable while out_ready is low.
- busy = (state != IDLE).
- Idle input cycles in FILL (in_valid low) hold state; the partial tile is kept indefinitely.
- Asserting rst mid-fill or mid-drain discards the tile. Every output returns to its reset value immediately.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, e_*_out=0, M=0, col=0, row=0, state=IDLE.
- Without the configuration macro: the 4th accept occurs at edge t; out_valid=1 with row 0 is visible after edge t, so fill-to-drain latency is 1 cycle.
- Row k is presented until its handshake. With out_ready held high, the drain takes exactly 4 cycles.
- in_ready returns high in the cycle after the row-3 handshake. A new tile can begin on that edge.
- in_valid asserted while in_ready=0 is ignored, not queued. The sender must hold the beat until it is accepted.
- The input and output of the same tile never overlap, so there is no simultaneous-event case within a tile.

## Configuration
- E_COLLECT_NXN_DESKEW_EN
  - Defined: inputs are systolically skewed. Line j carries the beat accepted at edge t at edge t+j, regardless of in_ready. Line j passes through 3-j delay registers (reset 0), and the accept strobe passes through a 3-stage delay. M is written from the aligned data and delayed strobe.
  - Defined: in_ready drops after the 4th accept is counted at the input side. FILL -> DRAIN occurs on the delayed 4th strobe, so fill-to-drain latency is 4 cycles.
  - Not defined: no delay registers; lines are aligned as described in Operation.

## Test plan
- Reset: with rst=0, then released → in_ready=1, out_valid=0, busy=0, all outputs 0.
- Basic transpose: feed 4 back-to-back beats where e_j_in = 8'h10*col + j, with out_ready=1 → rows out as {row k: e_c_out = 8'h10*c + k}; the first row appears 1 cycle after the 4th accept; in_ready=0 for exactly 4 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles during row 2 → row 2 data stays stable, row does not advance, and a beat offered with in_valid=1 is not accepted.
- Input gaps: in_valid pattern 1,0,0,1,1,0,1 → exactly 4 captures in order, and DRAIN is entered after the last one.
- Reset mid-drain: assert rst after row 1 has been handshaken → out_valid=0 asynchronously; after release, a fresh tile drains correctly starting from row 0.
- DESKEW build: drive line j delayed by j cycles with the same values as the basic transpose → identical row output, with first row_valid 4 cycles after the 4th accept.

Source files
------------

// File: rtl/e_collect_nxn.sv
// e_collect_nxn: column-to-row collector for the 4x4 LABFT datapath.
// Takes one column word per beat (element j on line j), stores the tile,
// then drains one row per beat on a valid/ready output. The tile comes out
// transposed back to row order.
// Optional feature macro: E_COLLECT_NXN_DESKEW_EN. When it is defined, the
// input lines are treated as systolically skewed and are realigned internally.
module e_collect_nxn #(
  parameter int arraySize = 4,
  parameter int zBits     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [zBits-1:0] e_0_in,
  input  logic [zBits-1:0] e_1_in,
  input  logic [zBits-1:0] e_2_in,
  input  logic [zBits-1:0] e_3_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [zBits-1:0] e_0_out,
  output logic [zBits-1:0] e_1_out,
  output logic [zBits-1:0] e_2_out,
  output logic [zBits-1:0] e_3_out,
  output logic             busy
);

  localparam int CW = $clog2(arraySize);
  localparam logic [CW-1:0] LAST = CW'(arraySize - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t           state;
  logic [zBits-1:0] m [arraySize][arraySize];
  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic             wr_en;
  logic [zBits-1:0] wr_data [arraySize];
  logic             drain_done;

  assign drain_done = (state == DRAIN) && out_ready && (row == LAST);

`ifdef E_COLLECT_NXN_DESKEW_EN
  // Line j arrives j cycles after its beat; delaying it by 3-j cycles and the
  // accept strobe by 3 cycles lines every element up with the strobe.
  logic [zBits-1:0] l0_q [3];
  logic [zBits-1:0] l1_q [2];
  logic [zBits-1:0] l2_q;
  logic [2:0]       stb_q;
  logic [CW-1:0]    in_col;
  logic             in_full;
  logic             acc;

  assign acc      = in_valid && in_ready;
  assign in_ready = !in_full;
  assign wr_en    = stb_q[2];

  // Deskew delay lines, delayed strobe and input-side beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l0_q[0] <= '0;
      l0_q[1] <= '0;
      l0_q[2] <= '0;
      l1_q[0] <= '0;
      l1_q[1] <= '0;
      l2_q    <= '0;
      stb_q   <= '0;
      in_col  <= '0;
      in_full <= 1'b0;
    end else begin
      l0_q[0] <= e_0_in;
      l0_q[1] <= l0_q[0];
      l0_q[2] <= l0_q[1];
      l1_q[0] <= e_1_in;
      l1_q[1] <= l1_q[0];
      l2_q    <= e_2_in;
      stb_q   <= {stb_q[1:0], acc};
      if (acc) begin
        in_col <= in_col + 1'b1;
        if (in_col == LAST) in_full <= 1'b1;
      end
      if (drain_done) in_full <= 1'b0;
    end
  end

  // Aligned write data taken from the ends of the delay lines
  always_comb begin
    wr_data[0] = l0_q[2];
    wr_data[1] = l1_q[1];
    wr_data[2] = l2_q;
    wr_data[3] = e_3_in;
  end
`else
  assign in_ready = (state != DRAIN);
  assign wr_en    = in_valid && in_ready;

  // Lines are already aligned; write straight from the inputs
  always_comb begin
    wr_data[0] = e_0_in;
    wr_data[1] = e_1_in;
    wr_data[2] = e_2_in;
    wr_data[3] = e_3_in;
  end
`endif

  // Tile storage, column/row counters and the IDLE/FILL/DRAIN sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      for (int unsigned i = 0; i < arraySize; i++) begin
        for (int unsigned j = 0; j < arraySize; j++) begin
          m[i][j] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        for (int unsigned j = 0; j < arraySize; j++) begin
          m[j][col] <= wr_data[j];
        end
        col <= col + 1'b1;
        if (col == LAST)       state <= DRAIN;
        else if (state == IDLE) state <= FILL;
      end
      if ((state == DRAIN) && out_ready) begin
        row <= row + 1'b1;
        if (row == LAST) state <= IDLE;
      end
    end
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);

  // Present the current row while draining, zeros otherwise
  always_comb begin
    e_0_out = '0;
    e_1_out = '0;
    e_2_out = '0;
    e_3_out = '0;
    if (out_valid) begin
      e_0_out = m[row][0];
      e_1_out = m[row][1];
      e_2_out = m[row][2];
      e_3_out = m[row][3];
    end
  end

endmodule

// File: tb/tb_e_collect_nxn.sv
// Directed self-checking bench for e_collect_nxn (default build).
module tb_e_collect_nxn;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] e_0_in, e_1_in, e_2_in, e_3_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] e_0_out, e_1_out, e_2_out, e_3_out;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  e_collect_nxn #(.arraySize(4), .zBits(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .e_0_in(e_0_in), .e_1_in(e_1_in), .e_2_in(e_2_in), .e_3_in(e_3_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .e_0_out(e_0_out), .e_1_out(e_1_out), .e_2_out(e_2_out), .e_3_out(e_3_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Column beat c of a tile with the given base: e_j_in = base + 0x10*c + j
  task automatic drive_col(input logic [7:0] base, input int c);
    e_0_in = base + 8'(16 * c) + 8'd0;
    e_1_in = base + 8'(16 * c) + 8'd1;
    e_2_in = base + 8'(16 * c) + 8'd2;
    e_3_in = base + 8'(16 * c) + 8'd3;
  endtask

  // Expected row k as {e_3_out, e_2_out, e_1_out, e_0_out}
  function automatic logic [31:0] exp_row(input logic [7:0] base, input int k);
    return {base + 8'h30 + 8'(k), base + 8'h20 + 8'(k),
            base + 8'h10 + 8'(k), base + 8'h00 + 8'(k)};
  endfunction

  function automatic logic [31:0] outs();
    return {e_3_out, e_2_out, e_1_out, e_0_out};
  endfunction

  task automatic fill(input logic [7:0] base);
    for (int c = 0; c < 4; c++) begin
      check("fill_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      drive_col(base, c);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_rows(input logic [7:0] base, input int first, input int last);
    out_ready = 1'b1;
    for (int k = first; k <= last; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_row", outs(), exp_row(base, k));
      check("drain_in_ready", 32'(in_ready), 32'd0);
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    e_0_in = '0; e_1_in = '0; e_2_in = '0; e_3_in = '0;

    // Reset state
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", outs(), 32'h0);
    #3 rst = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Basic transpose, out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive_col(8'h00, 0);
    step();
    check("basic_busy_after_first", 32'(busy), 32'd1);
    check("basic_no_valid_in_fill", 32'(out_valid), 32'd0);
    for (int c = 1; c < 4; c++) begin
      drive_col(8'h00, c);
      step();
    end
    in_valid = 1'b0;
    // one cycle after the 4th accept, row 0 is presented
    check("basic_row0_literal", outs(), 32'h30201000);
    drain_rows(8'h00, 0, 3);
    check("basic_done_valid", 32'(out_valid), 32'd0);
    check("basic_done_in_ready", 32'(in_ready), 32'd1);
    check("basic_done_busy", 32'(busy), 32'd0);
    check("basic_done_outs", outs(), 32'h0);

    // Back-pressure during row 2, with an input beat offered meanwhile
    fill(8'hA0);
    drain_rows(8'hA0, 0, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    e_0_in = 8'hFF; e_1_in = 8'hFF; e_2_in = 8'hFF; e_3_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_row2_stable", outs(), 32'hD3C3B3A3 - 32'h01010101);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain_rows(8'hA0, 2, 3);
    check("bp_ignored_beat_busy", 32'(busy), 32'd0);
    check("bp_done_in_ready", 32'(in_ready), 32'd1);

    // Input gaps: valid pattern 1,0,0,1,1,0,1
    begin
      logic [6:0] pat;
      int c;
      pat = 7'b1011001; // bit i = cycle i
      c = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
        in_valid = pat[i];
        if (pat[i]) begin
          drive_col(8'h40, c);
          c++;
        end else begin
          e_0_in = 8'hEE; e_1_in = 8'hEE; e_2_in = 8'hEE; e_3_in = 8'hEE;
        end
        step();
        if (i == 5) check("gap_not_drain_yet", 32'(out_valid), 32'd0);
        if (i == 2) check("gap_busy_hold", 32'(busy), 32'd1);
      end
      in_valid = 1'b0;
      check("gap_drain_entered", 32'(out_valid), 32'd1);
      drain_rows(8'h40, 0, 3);
      check("gap_done_busy", 32'(busy), 32'd0);
    end

    // Reset mid-drain after row 1 handshake
    fill(8'h80);
    drain_rows(8'h80, 0, 1);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_outs", outs(), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    #3 rst = 1'b1;
    step();
    fill(8'h08);
    check("fresh_row0_literal", outs(), 32'h38281808);
    drain_rows(8'h08, 0, 3);
    check("fresh_done_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
